// File: rtl/pipe_add_sub.sv
// pipe_add_sub: WIDTH-bit adder/subtractor split into STAGES carry-chained chunks, one chunk per
// clock, with valid/ready handshakes on both sides and bubble-collapsing per-stage flow control.
module pipe_add_sub #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int unsigned CW = WIDTH / STAGES;

   logic [STAGES-1:0] v_q, load, v_in;
   logic [STAGES-1:0] c_q, c_in, c_nx;
   // Per stage: finished sum chunks in the low bits, still-unused A chunks in the high bits.
   logic [WIDTH-1:0]  w_q  [STAGES];
   logic [WIDTH-1:0]  b_q  [STAGES];
   logic [WIDTH-1:0]  w_in [STAGES];
   logic [WIDTH-1:0]  b_in [STAGES];
   logic [WIDTH-1:0]  w_nx [STAGES];
   logic [CW:0]       chunk;
   logic              rdy;
   logic              ovf_q, zero_q, ovf_nx, zero_nx;

   always_comb begin : flow
      rdy = ~v_q[STAGES-1] | out_ready;
      load = '0;
      load[STAGES-1] = rdy;
      for (int unsigned k = 1; k < STAGES; k++) begin
         rdy = ~v_q[STAGES-1-k] | rdy;
         load[STAGES-1-k] = rdy;
      end
   end

   always_comb begin : datapath
      v_in[0] = in_valid;
      w_in[0] = a;
      b_in[0] = sub ? ~b : b;
      c_in[0] = sub | cin;
      for (int unsigned k = 1; k < STAGES; k++) begin
         v_in[k] = v_q[k-1];
         w_in[k] = w_q[k-1];
         b_in[k] = b_q[k-1];
         c_in[k] = c_q[k-1];
      end
      chunk = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         chunk = {1'b0, w_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
               + {{CW{1'b0}}, c_in[k]};
         w_nx[k] = w_in[k];
         w_nx[k][k*CW +: CW] = chunk[CW-1:0];
         c_nx[k] = chunk[CW];
      end
      // carry into the MSB recovered from the MSB's own sum bit
      ovf_nx  = w_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
              ^ w_nx[STAGES-1][WIDTH-1] ^ c_nx[STAGES-1];
      zero_nx = ~|w_nx[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= '0;
         c_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            w_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (load[k]) v_q[k] <= v_in[k];
            if (load[k] && v_in[k]) begin
               w_q[k] <= w_nx[k];
               b_q[k] <= b_in[k];
               c_q[k] <= c_nx[k];
            end
         end
         if (load[STAGES-1] && v_in[STAGES-1]) begin
            ovf_q  <= ovf_nx;
            zero_q <= zero_nx;
         end
      end
   end

   assign in_ready  = load[0];
   assign out_valid = v_q[STAGES-1];
   assign sum       = w_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: randomized and directed checks of pipe_add_sub against an arithmetic
// reference model with a result scoreboard.
module tb_pipe_add_sub;
   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 4;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        cin;
      res_t        e;
   } vec_t;

   logic        clk, rst_n, in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
   logic [31:0] a, b, sum;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   res_t        exp_q[$];

   pipe_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic s, input logic ci);
      logic [32:0] u;
      longint      sr;
      res_t        r;
      if (s) begin
         u      = {1'b0, x} - {1'b0, y};
         r.cout = (x >= y);
         sr     = longint'($signed(x)) - longint'($signed(y));
      end else begin
         u      = {1'b0, x} + {1'b0, y} + {32'd0, ci};
         r.cout = u[32];
         sr     = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      end
      r.sum  = u[31:0];
      r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      r.zero = (r.sum == 32'd0);
      return r;
   endfunction

   function automatic res_t observed();
      return {sum, cout, ovf, zero};
   endfunction

   function automatic string fmt(input res_t r);
      return $sformatf("sum=%h cout=%b ovf=%b zero=%b", r.sum, r.cout, r.ovf, r.zero);
   endfunction

   task automatic drive_stream(input int n, input int max_idle);
      int guard;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         repeat ($urandom_range(max_idle, 0)) @(negedge clk);
         a        = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
         b        = ($urandom_range(7, 0) == 0) ? a : $urandom;
         sub      = 1'($urandom_range(1, 0));
         cin      = 1'($urandom_range(1, 0));
         in_valid = 1'b1;
         #1;
         guard = 0;
         while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
         end
         if (guard >= 200) begin
            n_total++;
            $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
         end
         exp_q.push_back(model(a, b, sub, cin));
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
      else n_pass++;
      n_total++;
      if (observed() !== '0) $display("FAIL reset_outputs: got %s, required all zero", fmt(observed()));
      else n_pass++;
      rst_n = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_directed();
      vec_t tab[7] = '{
         '{32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}},
         '{32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}},
         '{32'h8000_0000, 32'd1, 1'b1, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}},
         '{32'd5,         32'd7, 1'b1, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}},
         '{32'd7,         32'd7, 1'b1, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}},
         '{32'd1,         32'd2, 1'b0, 1'b1, '{32'h0000_0004, 1'b0, 1'b0, 1'b0}},
         '{32'd10,        32'd3, 1'b1, 1'b1, '{32'h0000_0007, 1'b1, 1'b0, 1'b0}}
      };
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         a = tab[i].a; b = tab[i].b; sub = tab[i].sub; cin = tab[i].cin; in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         n_total++;
         if (lat != 4) $display("FAIL directed_latency[%0d]: got %0d cycles, required 4", i, lat);
         else n_pass++;
         n_total++;
         if (observed() !== tab[i].e)
            $display("FAIL directed_result[%0d]: got %s, required %s", i, fmt(observed()), fmt(tab[i].e));
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int got, cyc, gaps;
      bit started;
      res_t e;
      out_ready = 1'b1;
      exp_q.delete();
      got = 0; cyc = 0; gaps = 0; started = 1'b0;
      fork
         drive_stream(100, 0);
         begin
            while (got < 100 && cyc < 1000) begin
               @(negedge clk);
               #1;
               cyc++;
               if (out_valid) begin
                  started = 1'b1;
                  n_total++;
                  if (exp_q.size() == 0) $display("FAIL b2b_spurious: got %s, required no result", fmt(observed()));
                  else begin
                     e = exp_q.pop_front();
                     if (observed() !== e) $display("FAIL b2b_result[%0d]: got %s, required %s", got, fmt(observed()), fmt(e));
                     else n_pass++;
                  end
                  got++;
               end else if (started) gaps++;
            end
         end
      join
      n_total++;
      if (got != 100) $display("FAIL b2b_count: got %0d results, required 100", got);
      else n_pass++;
      n_total++;
      if (gaps != 0) $display("FAIL b2b_gaps: got %0d idle cycles, required 0", gaps);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int got, cyc, hold;
      res_t e, snap;
      out_ready = 1'b1;
      exp_q.delete();
      got = 0; cyc = 0; hold = 0; snap = '0;
      fork
         drive_stream(20, 0);
         begin
            while (got < 20 && cyc < 1000) begin
               @(negedge clk);
               out_ready = !(got == 3 && hold < 10);
               #1;
               cyc++;
               if (!out_ready) begin
                  hold++;
                  n_total++;
                  if (hold == 1) begin
                     snap = observed();
                     if (out_valid !== 1'b1) $display("FAIL bp_valid_at_stall: got %b, required 1", out_valid);
                     else n_pass++;
                  end else begin
                     if ({out_valid, observed()} !== {1'b1, snap})
                        $display("FAIL bp_stable[%0d]: got valid=%b %s, required valid=1 %s", hold, out_valid, fmt(observed()), fmt(snap));
                     else n_pass++;
                  end
                  if (hold == 10) begin
                     n_total++;
                     if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b, required 0", in_ready);
                     else n_pass++;
                  end
               end else if (out_valid) begin
                  n_total++;
                  if (exp_q.size() == 0) $display("FAIL bp_spurious: got %s, required no result", fmt(observed()));
                  else begin
                     e = exp_q.pop_front();
                     if (observed() !== e) $display("FAIL bp_result[%0d]: got %s, required %s", got, fmt(observed()), fmt(e));
                     else n_pass++;
                  end
                  got++;
               end
            end
         end
      join
      n_total++;
      if (got != 20 || exp_q.size() != 0)
         $display("FAIL bp_count: got %0d results with %0d left, required 20 with 0 left", got, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_random_flow();
      int got, cyc;
      bit stalled;
      res_t e, prev;
      exp_q.delete();
      got = 0; cyc = 0; stalled = 1'b0; prev = '0;
      fork
         drive_stream(60, 2);
         begin
            while (got < 60 && cyc < 2000) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(1, 0));
               #1;
               cyc++;
               if (stalled) begin
                  n_total++;
                  if ({out_valid, observed()} !== {1'b1, prev})
                     $display("FAIL rnd_hold: got valid=%b %s, required valid=1 %s", out_valid, fmt(observed()), fmt(prev));
                  else n_pass++;
               end
               stalled = out_valid && !out_ready;
               prev    = observed();
               if (out_valid && out_ready) begin
                  n_total++;
                  if (exp_q.size() == 0) $display("FAIL rnd_spurious: got %s, required no result", fmt(observed()));
                  else begin
                     e = exp_q.pop_front();
                     if (observed() !== e) $display("FAIL rnd_result[%0d]: got %s, required %s", got, fmt(observed()), fmt(e));
                     else n_pass++;
                  end
                  got++;
               end
            end
         end
      join
      n_total++;
      if (got != 60) $display("FAIL rnd_count: got %0d results, required 60", got);
      else n_pass++;
      out_ready = 1'b1;
   endtask

   task automatic test_reset_midflight();
      int lat, spurious;
      res_t e;
      exp_q.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = $urandom; b = $urandom; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b, required 1", out_valid);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", out_valid);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      spurious = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (out_valid) spurious++;
      end
      n_total++;
      if (spurious != 0) $display("FAIL rst_discard: got %0d valid cycles, required 0", spurious);
      else n_pass++;
      @(negedge clk);
      a = $urandom; b = $urandom; sub = 1'b1; cin = 1'b0; in_valid = 1'b1;
      e = model(a, b, sub, cin);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      n_total++;
      if (lat != 4) $display("FAIL rst_after_latency: got %0d cycles, required 4", lat);
      else n_pass++;
      n_total++;
      if (observed() !== e) $display("FAIL rst_after_result: got %s, required %s", fmt(observed()), fmt(e));
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random_flow();
      test_reset_midflight();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
